// File: rtl/time_of_day_counter_if.sv
// Purpose: bundles the time-of-day counter's button/tick inputs and its time/status outputs.
// Latency: none; this is wiring only.
// Backpressure: none; inputs are level/pulse signals and outputs are always valid.
//
// Signals:
//   tick_in    divided-clock level from the clock divider (clk_in domain)
//   mode_btn   one-cycle pulse: advance set-mode state
//   inc_btn    one-cycle pulse: increment the field selected by the current mode
//   sec, min   seconds / minutes, 0..59
//   hour       displayed hour (0..23, or 1..12 in the 12-hour build)
//   pm         PM flag (12-hour build only, else 0)
//   mode       0=RUN 1=SET_HOUR 2=SET_MIN
//   min_pulse  one-cycle pulse on a minute carry
//   day_pulse  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap
// master drives the inputs and reads the time; slave is the counter itself.
interface time_of_day_counter_if;
    logic       tick_in;
    logic       mode_btn;
    logic       inc_btn;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       pm;
    logic [1:0] mode;
    logic       min_pulse;
    logic       day_pulse;

    modport master (
        output tick_in, mode_btn, inc_btn,
        input  sec, min, hour, pm, mode, min_pulse, day_pulse
    );

    modport slave (
        input  tick_in, mode_btn, inc_btn,
        output sec, min, hour, pm, mode, min_pulse, day_pulse
    );
endinterface

// File: rtl/time_of_day_counter.sv
// Purpose: hh:mm:ss counter with button-driven set mode, stepped by rising edges of a 1 Hz level.
// Latency: outputs update on the clk_in edge that first samples tick_in high (TICK_DIV rises per second).
// Backpressure: none; every accepted rise or button pulse is consumed in the cycle it is sampled.
//
// Ports:
//   clk_in     system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   tod        time_of_day_counter_if.slave (tick_in, mode_btn, inc_btn in; sec, min, hour,
//              pm, mode, min_pulse, day_pulse out)
// Parameters:
//   TICK_DIV   tick_in rises per second step (>=1)
//   RESET_HOUR internal hour (0..23) loaded on reset
// Build option:
//   TWELVE_HOUR_EN  when defined, hour is shown as 1..12 with pm; otherwise hour is 0..23, pm=0.
//   The internal hour register is 0..23 in both builds.
module time_of_day_counter #(
    parameter int TICK_DIV   = 1,
    parameter int RESET_HOUR = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    time_of_day_counter_if.slave  tod
);

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;

    // A one-bit divider register is kept even for TICK_DIV=1 so the compare below stays legal;
    // it then never leaves 0 and every rise is a step.
    localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [4:0]       H_RESET  = 5'(RESET_HOUR);

    logic             tick_q;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       sec_q;
    logic [5:0]       min_q;
    logic [4:0]       h_q;
    logic [1:0]       mode_q;
    logic             min_pulse_q;
    logic             day_pulse_q;

    logic rise;
    logic sec_last;
    logic min_last;
    logic h_last;

    assign rise     = tod.tick_in & ~tick_q;
    assign sec_last = (sec_q == 6'd59);
    assign min_last = (min_q == 6'd59);
    assign h_last   = (h_q == 5'd23);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_q      <= 1'b0;
            div_cnt     <= '0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            h_q         <= H_RESET;
            mode_q      <= MODE_RUN;
            min_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            tick_q      <= tod.tick_in;
            min_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;

            if (tod.mode_btn) begin
                // Mode change wins over a same-cycle rise or inc_btn, which are dropped.
                case (mode_q)
                    MODE_RUN: begin
                        mode_q  <= MODE_SET_HOUR;
                        sec_q   <= 6'd0;
                        div_cnt <= '0;
                    end
                    MODE_SET_HOUR: begin
                        mode_q <= MODE_SET_MIN;
                    end
                    default: begin
                        // Back to RUN with a fresh second: the next step needs a full TICK_DIV rises.
                        mode_q  <= MODE_RUN;
                        sec_q   <= 6'd0;
                        div_cnt <= '0;
                    end
                endcase
            end else begin
                case (mode_q)
                    MODE_RUN: begin
                        if (rise) begin
                            if (div_cnt == DIV_LAST) begin
                                div_cnt <= '0;
                                if (sec_last) begin
                                    sec_q       <= 6'd0;
                                    min_pulse_q <= 1'b1;
                                    if (min_last) begin
                                        min_q <= 6'd0;
                                        if (h_last) begin
                                            h_q         <= 5'd0;
                                            day_pulse_q <= 1'b1;
                                        end else begin
                                            h_q <= h_q + 5'd1;
                                        end
                                    end else begin
                                        min_q <= min_q + 6'd1;
                                    end
                                end else begin
                                    sec_q <= sec_q + 6'd1;
                                end
                            end else begin
                                div_cnt <= div_cnt + 1'b1;
                            end
                        end
                    end
                    MODE_SET_HOUR: begin
                        if (tod.inc_btn) begin
                            h_q <= h_last ? 5'd0 : h_q + 5'd1;
                        end
                    end
                    MODE_SET_MIN: begin
                        // Minute setting wraps on its own; it never carries into the hour.
                        if (tod.inc_btn) begin
                            min_q <= min_last ? 6'd0 : min_q + 6'd1;
                        end
                    end
                    default: begin
                        // Encoding 3 cannot be entered; recover to RUN if it ever appears.
                        mode_q <= MODE_RUN;
                    end
                endcase
            end
        end
    end

    assign tod.sec       = sec_q;
    assign tod.min       = min_q;
    assign tod.mode      = mode_q;
    assign tod.min_pulse = min_pulse_q;
    assign tod.day_pulse = day_pulse_q;

`ifdef TWELVE_HOUR_EN
    // h%12 without a divider: h is at most 23, so one conditional subtract suffices.
    logic [4:0] h_mod12;
    assign h_mod12  = (h_q >= 5'd12) ? (h_q - 5'd12) : h_q;
    assign tod.hour = (h_mod12 == 5'd0) ? 5'd12 : h_mod12;
    assign tod.pm   = (h_q >= 5'd12);
`else
    assign tod.hour = h_q;
    assign tod.pm   = 1'b0;
`endif

endmodule
